matrix_source_rt: RTL
=====================

Name: matrix_source_rt

Overview:
Real-time AXI-Stream stimulus transmitter feeding operand words into the matrix multiplier's input_r stream port. It is the transmitting counterpart of the matrix result checker. After reset and enable, it waits a start delay, then sends a fixed number of frames of 32-bit words with TLAST on each frame's final word. It reports the number of completed frames, completion, and a stall watchdog timeout.

Parameters:
Num_Words, 216, words per frame (1..1023)
Num_Frames, 4, frames to send before Done (1..15)
Data_Value, 32'd12, constant word value / base value for incrementing pattern
Pattern_Mode, 0, 0 = every word Data_Value; 1 = Data_Value + word index (mod 2^32)
Start_Delay, 20, clk cycles between enable acceptance and first TVALID (0 allowed)
Gap_Cycles, 8, idle cycles (TVALID=0) between frames (0 = back-to-back)
Stop_Counter_Value, 20'd20000, consecutive stall cycles (TVALID=1, TREADY=0) that trigger Timeout

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  start request, sampled only in IDLE
input_r_TREADY_0  input  1  sink ready
input_r_TVALID_0  output  1  word valid
input_r_TLAST_0  output  1  last word of frame
input_r_TDATA_0  output  32  word data
Frame_Counter  output  4  frames fully transferred (saturates at Num_Frames)
Done  output  1  all frames sent, sticky until reset
Timeout  output  1  watchdog fired, sticky until reset

Behaviour:
- Reset (async, active-high): state IDLE; TVALID=0, TLAST=0, TDATA=0, Frame_Counter=0, Done=0, Timeout=0, word/delay/gap/stall counters 0. Reset mid-frame aborts immediately; no partial frame resumes.
- Transfer = TVALID & TREADY at rising clk edge.
- States: IDLE, DELAY, SEND, GAP, DONE, TIMEOUT.
- IDLE: enable=1 -> DELAY (Start_Delay>0) or SEND (Start_Delay=0). Outputs idle.
- DELAY: counts Start_Delay cycles; first TVALID high exactly Start_Delay+1 cycles after the edge sampling enable.
- SEND: TVALID=1; TDATA = Data_Value (mode 0) or Data_Value + word_idx (mode 1, word_idx restarts at 0 each frame); TLAST=1 iff word_idx==Num_Words-1.
- AXI rule: while TVALID=1 and no transfer, TDATA/TLAST held stable; TVALID never deasserted without transfer except on Timeout.
- On transfer, word_idx increments, next word presented next cycle (one word per cycle at full throughput, no bubbles).
- On TLAST transfer: Frame_Counter+1 same edge; if new count==Num_Frames -> DONE; else Gap_Cycles>0 -> GAP, Gap_Cycles=0 -> stay SEND with word_idx=0 (TVALID stays high).
- GAP: TVALID=0 for exactly Gap_Cycles cycles, then SEND with word_idx=0.
- DONE: Done=1, TVALID=0, TLAST=0; enable ignored; exit only by reset.
- Watchdog: stall counter increments each cycle in SEND with TREADY=0; clears on transfer and outside SEND. Reaching Stop_Counter_Value -> TIMEOUT next edge: TVALID=0, Timeout=1 (intentional protocol abort), Frame_Counter frozen; exit only by reset.
- enable deasserted after start has no effect.
- Num_Words=1: every word has TLAST=1.
- TDATA increment wraps modulo 2^32 without error.

Test Plan:
- Defaults, TREADY tied 1, enable pulse at t=250 ns -> TVALID rises 21 cycles later, 216 consecutive transfers, TLAST on word 216 only, TDATA=12 throughout, 8-cycle gap, 4 frames, Frame_Counter=4, Done=1.
- Pattern_Mode=1, Data_Value=32'hFFFFFFFE, Num_Words=4 -> TDATA FFFFFFFE, FFFFFFFF, 0, 1 per frame, restarting each frame.
- Random TREADY (50%) -> TDATA/TLAST stable across every stall; total 864 transfers; Done=1; no dropped or duplicated words.
- Gap_Cycles=0, Num_Frames=2 -> TVALID continuous across frame boundary; word after first TLAST has word_idx 0.
- TREADY held 0, Stop_Counter_Value=100 -> after 100 stall cycles TVALID=0, Timeout=1, Frame_Counter=0, Done=0.
- reset asserted mid-frame (word 50) -> outputs clear asynchronously; after release and new enable, frame restarts at word 0, Frame_Counter=0.

Source files
------------

// File: rtl/matrix_source_rt_if.sv
// AXI-Stream word channel between the stimulus source and its sink.
interface matrix_source_rt_if;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [31:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/matrix_source_rt.sv
// Real-time AXI-Stream stimulus source: after enable and a start delay, sends
// Num_Frames frames of Num_Words words, with a stall watchdog.
module matrix_source_rt #(
    parameter int unsigned Num_Words          = 216,
    parameter int unsigned Num_Frames         = 4,
    parameter logic [31:0] Data_Value         = 32'd12,
    parameter int unsigned Pattern_Mode       = 0,
    parameter int unsigned Start_Delay        = 20,
    parameter int unsigned Gap_Cycles         = 8,
    parameter logic [19:0] Stop_Counter_Value = 20'd20000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    matrix_source_rt_if.master        input_r,
    output logic [3:0]                Frame_Counter,
    output logic                      Done,
    output logic                      Timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_SEND,
        S_GAP,
        S_DONE,
        S_TIMEOUT
    } state_t;

    localparam logic [9:0]  LAST_IDX   = 10'(Num_Words - 1);
    localparam logic [3:0]  FRAMES     = 4'(Num_Frames);
    localparam logic [31:0] DELAY_LAST = 32'(Start_Delay - 1);
    localparam logic [31:0] GAP_LAST   = 32'(Gap_Cycles - 1);
    localparam logic [19:0] STALL_LAST = Stop_Counter_Value - 20'd1;

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [9:0]  idx, idx_n, idx_inc;
    logic [19:0] stall, stall_n;
    logic        tvalid_q, tvalid_n;
    logic        tlast_q, tlast_n;
    logic [31:0] tdata_q, tdata_n;
    logic [3:0]  fc_q, fc_n, fc_inc;
    logic        done_q, done_n;
    logic        timeout_q, timeout_n;

    function automatic logic [31:0] word_at(input logic [9:0] i);
        return (Pattern_Mode != 0) ? Data_Value + {22'd0, i} : Data_Value;
    endfunction

    assign idx_inc = idx + 10'd1;
    assign fc_inc  = fc_q + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            stall     <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= '0;
            fc_q      <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            stall     <= stall_n;
            tvalid_q  <= tvalid_n;
            tlast_q   <= tlast_n;
            tdata_q   <= tdata_n;
            fc_q      <= fc_n;
            done_q    <= done_n;
            timeout_q <= timeout_n;
        end
    end

    // Outputs are registered, so SEND entered from IDLE/DELAY spends one cycle
    // loading word 0; GAP preloads it so the idle gap is exactly Gap_Cycles.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        stall_n   = stall;
        tvalid_n  = tvalid_q;
        tlast_n   = tlast_q;
        tdata_n   = tdata_q;
        fc_n      = fc_q;
        done_n    = done_q;
        timeout_n = timeout_q;

        case (state)
            S_IDLE: begin
                if (enable) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = (Start_Delay == 0) ? S_SEND : S_DELAY;
                end
            end
            S_DELAY: begin
                if (cnt == DELAY_LAST) begin
                    state_n = S_SEND;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            S_SEND: begin
                if (!tvalid_q) begin
                    tvalid_n = 1'b1;
                    tdata_n  = word_at(idx);
                    tlast_n  = (idx == LAST_IDX);
                end else if (input_r.tready) begin
                    stall_n = '0;
                    if (tlast_q) begin
                        fc_n  = fc_inc;
                        idx_n = '0;
                        if (fc_inc == FRAMES) begin
                            state_n  = S_DONE;
                            tvalid_n = 1'b0;
                            tlast_n  = 1'b0;
                            done_n   = 1'b1;
                        end else if (Gap_Cycles == 0) begin
                            tdata_n = word_at(10'd0);
                            tlast_n = (LAST_IDX == 10'd0);
                        end else begin
                            state_n  = S_GAP;
                            cnt_n    = '0;
                            tvalid_n = 1'b0;
                            tlast_n  = 1'b0;
                        end
                    end else begin
                        idx_n   = idx_inc;
                        tdata_n = word_at(idx_inc);
                        tlast_n = (idx_inc == LAST_IDX);
                    end
                end else if (stall == STALL_LAST) begin
                    state_n   = S_TIMEOUT;
                    stall_n   = '0;
                    tvalid_n  = 1'b0;
                    tlast_n   = 1'b0;
                    timeout_n = 1'b1;
                end else begin
                    stall_n = stall + 20'd1;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n  = S_SEND;
                    cnt_n    = '0;
                    tvalid_n = 1'b1;
                    tdata_n  = word_at(10'd0);
                    tlast_n  = (LAST_IDX == 10'd0);
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            S_DONE, S_TIMEOUT: begin
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign input_r.tvalid = tvalid_q;
    assign input_r.tlast  = tlast_q;
    assign input_r.tdata  = tdata_q;
    assign Frame_Counter  = fc_q;
    assign Done           = done_q;
    assign Timeout        = timeout_q;

endmodule
